bw_mac_accumulator: RTL and testbench



---
 rtl/bw_mac_accumulator_pkg.sv | 20 ++
 rtl/bw_mac_accumulator_if.sv | 37 +++
 rtl/bw_sat_add.sv | 37 +++
 rtl/bw_mac_accumulator.sv | 114 +++++++++++
 tb/tb_bw_mac_accumulator.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bw_mac_accumulator_pkg.sv
// Shared types and helpers for the Baugh-Wooley MAC accumulator stage.
package bw_mac_accumulator_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int PROD_W_DEF = 8;

  // Two's-complement bounds for a given width, returned wide so callers can slice.
  function automatic logic signed [63:0] signedMax(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] signedMin(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/bw_mac_accumulator_if.sv
// Product-in / result-out handshakes of the MAC accumulator stage.
interface bw_mac_accumulator_if
  import bw_mac_accumulator_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = 12
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic signed [PROD_W-1:0] in_prod;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_sum;
  logic                     out_sat;

  modport master (
    output in_valid,
    output in_prod,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_sat
  );

  modport slave (
    input  in_valid,
    input  in_prod,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_sat
  );

endinterface

// File: rtl/bw_sat_add.sv
// Combinational signed adder that clamps to the ACC_W two's-complement range.
module bw_sat_add
  import bw_mac_accumulator_pkg::*;
#(
  parameter int ACC_W = 12
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic signed [ACC_W-1:0] opnd_i,
  output logic signed [ACC_W-1:0] sum_o,
  output logic                    sat_o
);

  localparam logic signed [63:0]      MAX64  = signedMax(ACC_W);
  localparam logic signed [63:0]      MIN64  = signedMin(ACC_W);
  localparam logic signed [ACC_W:0]   MAX_W  = MAX64[ACC_W:0];
  localparam logic signed [ACC_W:0]   MIN_W  = MIN64[ACC_W:0];
  localparam logic signed [ACC_W-1:0] MAX_V  = MAX64[ACC_W-1:0];
  localparam logic signed [ACC_W-1:0] MIN_V  = MIN64[ACC_W-1:0];

  logic signed [ACC_W:0] wideSum;

  // One extra bit is enough to hold any sum of two ACC_W operands exactly.
  assign wideSum = (ACC_W + 1)'(acc_i) + (ACC_W + 1)'(opnd_i);

  always_comb begin
    sum_o = wideSum[ACC_W-1:0];
    sat_o = 1'b0;
    if (wideSum > MAX_W) begin
      sum_o = MAX_V;
      sat_o = 1'b1;
    end else if (wideSum < MIN_W) begin
      sum_o = MIN_V;
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/bw_mac_accumulator.sv
// Accumulates FRAME_LEN signed products into a saturating sum and hands the
// result downstream through a valid/ready handshake.
module bw_mac_accumulator
  import bw_mac_accumulator_pkg::*;
#(
  parameter int PROD_W    = PROD_W_DEF,
  parameter int ACC_W     = 12,
  parameter int FRAME_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  bw_mac_accumulator_if.slave  bus
);

  localparam int                CNT_W    = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    satFlag_q, satFlag_d;
  logic                    outValid_q, outValid_d;
  logic signed [ACC_W-1:0] outSum_q, outSum_d;
  logic                    outSat_q, outSat_d;

  logic signed [ACC_W-1:0] prodExt;
  logic signed [ACC_W-1:0] addSum;
  logic                    addSat;

  assign prodExt = ACC_W'(bus.in_prod);

  bw_sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .acc_i  (acc_q),
    .opnd_i (prodExt),
    .sum_o  (addSum),
    .sat_o  (addSat)
  );

  // clr outranks everything; in HOLD the input side is closed entirely.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    satFlag_d  = satFlag_q;
    outValid_d = outValid_q;
    outSum_d   = outSum_q;
    outSat_d   = outSat_q;
    if (clr) begin
      state_d    = ACCUM;
      acc_d      = '0;
      cnt_d      = '0;
      satFlag_d  = 1'b0;
      outValid_d = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (bus.in_valid) begin
            if (cnt_q == LAST_CNT) begin
              outSum_d   = addSum;
              outSat_d   = satFlag_q | addSat;
              outValid_d = 1'b1;
              state_d    = HOLD;
              acc_d      = '0;
              cnt_d      = '0;
              satFlag_d  = 1'b0;
            end else begin
              acc_d     = addSum;
              cnt_d     = cnt_q + CNT_W'(1);
              satFlag_d = satFlag_q | addSat;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            outValid_d = 1'b0;
            state_d    = ACCUM;
          end
        end
        default: begin
          state_d = ACCUM;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      satFlag_q  <= 1'b0;
      outValid_q <= 1'b0;
      outSum_q   <= '0;
      outSat_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      satFlag_q  <= satFlag_d;
      outValid_q <= outValid_d;
      outSum_q   <= outSum_d;
      outSat_q   <= outSat_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = outValid_q;
  assign bus.out_sum   = outSum_q;
  assign bus.out_sat   = outSat_q;

endmodule

// File: tb/tb_bw_mac_accumulator.sv
// Drives three accumulator configurations with one shared stimulus stream and
// compares every cycle against a frame-level reference model.
module tb_bw_mac_accumulator;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       clr      = 1'b0;
  logic       inValid  = 1'b0;
  logic       outReady = 1'b0;
  logic [7:0] inProd   = 8'd0;

  always #5 clk = ~clk;

  bw_mac_accumulator_if #(.PROD_W(8), .ACC_W(12)) ifA ();
  bw_mac_accumulator_if #(.PROD_W(8), .ACC_W(8))  ifB ();
  bw_mac_accumulator_if #(.PROD_W(8), .ACC_W(12)) ifC ();

  assign ifA.in_valid = inValid;
  assign ifA.in_prod = inProd;
  assign ifA.out_ready = outReady;
  assign ifB.in_valid = inValid;
  assign ifB.in_prod = inProd;
  assign ifB.out_ready = outReady;
  assign ifC.in_valid = inValid;
  assign ifC.in_prod = inProd;
  assign ifC.out_ready = outReady;

  bw_mac_accumulator #(.PROD_W(8), .ACC_W(12), .FRAME_LEN(4)) dutA (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(ifA.slave));
  bw_mac_accumulator #(.PROD_W(8), .ACC_W(8), .FRAME_LEN(4)) dutB (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(ifB.slave));
  bw_mac_accumulator #(.PROD_W(8), .ACC_W(12), .FRAME_LEN(1)) dutC (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(ifC.slave));

  int accW[3]     = '{12, 8, 12};
  int frameLen[3] = '{4, 4, 1};
  int cnt[3];
  int prods[3][4];
  bit expValid[3];
  int expSum[3];
  bit expSat[3];

  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Field 0 in_ready, 1 out_valid, 2 out_sum (sign-extended), 3 out_sat.
  function automatic int obs(input int i, input int f);
    int r;
    r = 0;
    case (i)
      0: case (f)
           0: r = int'(ifA.in_ready);
           1: r = int'(ifA.out_valid);
           2: r = int'($signed(ifA.out_sum));
           default: r = int'(ifA.out_sat);
         endcase
      1: case (f)
           0: r = int'(ifB.in_ready);
           1: r = int'(ifB.out_valid);
           2: r = int'($signed(ifB.out_sum));
           default: r = int'(ifB.out_sat);
         endcase
      default: case (f)
           0: r = int'(ifC.in_ready);
           1: r = int'(ifC.out_valid);
           2: r = int'($signed(ifC.out_sum));
           default: r = int'(ifC.out_sat);
         endcase
    endcase
    return r;
  endfunction

  task automatic frameResult(input int i);
    int hi;
    int lo;
    int acc;
    bit sat;
    hi  = (1 << (accW[i] - 1)) - 1;
    lo  = -(1 << (accW[i] - 1));
    acc = 0;
    sat = 1'b0;
    for (int k = 0; k < frameLen[i]; k++) begin
      acc = acc + prods[i][k];
      if (acc > hi) begin
        acc = hi;
        sat = 1'b1;
      end else if (acc < lo) begin
        acc = lo;
        sat = 1'b1;
      end
    end
    expSum[i] = acc;
    expSat[i] = sat;
  endtask

  task automatic modelStep();
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        expValid[i] = 1'b0;
        cnt[i]      = 0;
      end else if (expValid[i]) begin
        if (outReady) expValid[i] = 1'b0;
      end else if (inValid) begin
        prods[i][cnt[i]] = int'($signed(inProd));
        cnt[i]++;
        if (cnt[i] == frameLen[i]) begin
          frameResult(i);
          expValid[i] = 1'b1;
          cnt[i]      = 0;
        end
      end
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      cnt[i]      = 0;
      expValid[i] = 1'b0;
      expSum[i]   = 0;
      expSat[i]   = 1'b0;
    end
  endtask

  task automatic checkAll(input string phase);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("%s.dut%0d.in_ready", phase, i), obs(i, 0), int'(!expValid[i]));
      checkOutput($sformatf("%s.dut%0d.out_valid", phase, i), obs(i, 1), int'(expValid[i]));
      checkOutput($sformatf("%s.dut%0d.out_sum", phase, i), obs(i, 2), expSum[i]);
      checkOutput($sformatf("%s.dut%0d.out_sat", phase, i), obs(i, 3), int'(expSat[i]));
    end
  endtask

  task automatic applyStimulus(input bit v, input int p, input bit r, input bit c, input string phase);
    inValid  = v;
    inProd   = p[7:0];
    outReady = r;
    clr      = c;
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkAll(phase);
  endtask

  // Called at a falling edge; returns with reset released before the next rising edge.
  task automatic asyncReset(input string phase);
    #1 rst_n = 1'b0;
    modelReset();
    #1 checkAll(phase);
    #1 rst_n = 1'b1;
  endtask

  int idle;
  int prodList[4];

  initial begin
    modelReset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    checkAll("reset");
    #1 rst_n = 1'b1;

    applyStimulus(1, 3, 0, 0, "tp1");
    applyStimulus(1, 5, 0, 0, "tp1");
    asyncReset("tp1.midreset");
    prodList = '{1, 2, 3, 4};
    foreach (prodList[k]) applyStimulus(1, prodList[k], 0, 0, "tp1.frame");
    checkOutput("tp1.sumA", obs(0, 2), 10);
    applyStimulus(0, 0, 1, 0, "tp1.drain");

    prodList = '{49, -56, 64, 7};
    foreach (prodList[k]) applyStimulus(1, prodList[k], 0, 0, "tp2");
    checkOutput("tp2.validA", obs(0, 1), 1);
    checkOutput("tp2.sumA", obs(0, 2), 64);
    checkOutput("tp2.satA", obs(0, 3), 0);

    repeat (5) applyStimulus(1, 9, 0, 0, "tp3.hold");
    checkOutput("tp3.sumA", obs(0, 2), 64);
    checkOutput("tp3.readyA", obs(0, 0), 0);
    applyStimulus(0, 0, 1, 0, "tp3.release");
    checkOutput("tp3.releaseA", obs(0, 0), 1);

    prodList = '{64, 64, -56, -56};
    foreach (prodList[k]) applyStimulus(1, prodList[k], 0, 0, "tp4a");
    checkOutput("tp4a.sumB", obs(1, 2), 15);
    checkOutput("tp4a.satB", obs(1, 3), 1);
    applyStimulus(0, 0, 1, 0, "tp4.drain");
    repeat (4) applyStimulus(1, -56, 0, 0, "tp4b");
    checkOutput("tp4b.sumB", obs(1, 2), -128);
    checkOutput("tp4b.satB", obs(1, 3), 1);
    applyStimulus(0, 0, 1, 0, "tp4.drain");
    repeat (4) applyStimulus(1, 1, 0, 0, "tp4c");
    checkOutput("tp4c.satB", obs(1, 3), 0);
    applyStimulus(0, 0, 1, 0, "tp4.drain");

    applyStimulus(1, 7, 0, 0, "tp5");
    applyStimulus(1, 7, 0, 0, "tp5");
    applyStimulus(1, 7, 0, 1, "tp5.clr");
    prodList = '{1, 2, 3, 4};
    foreach (prodList[k]) applyStimulus(1, prodList[k], 0, 0, "tp5.frame");
    checkOutput("tp5.sumA", obs(0, 2), 10);
    applyStimulus(0, 0, 0, 1, "tp5.clrhold");
    checkOutput("tp5.clrholdA", obs(0, 1), 0);

    applyStimulus(1, 5, 0, 0, "tp6");
    repeat (3) applyStimulus(0, 0, 0, 0, "tp6.gap");
    applyStimulus(1, -3, 0, 0, "tp6");
    applyStimulus(0, 0, 0, 0, "tp6.gap");
    applyStimulus(1, 2, 0, 0, "tp6");
    checkOutput("tp6.notyetA", obs(0, 1), 0);
    applyStimulus(1, 1, 0, 0, "tp6");
    checkOutput("tp6.sumA", obs(0, 2), 5);
    applyStimulus(0, 0, 1, 0, "tp6.drain");
    applyStimulus(1, -7, 0, 0, "tp6.len1");
    checkOutput("tp6.len1C", obs(2, 2), -7);
    applyStimulus(0, 0, 1, 0, "tp6.drain");
    applyStimulus(1, 33, 0, 0, "tp6.len1");
    checkOutput("tp6.len1C2", obs(2, 2), 33);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        asyncReset("rand.reset");
      end
      idle = ($urandom_range(0, 99) < 70) ? 1 : 0;
      applyStimulus(idle[0],
                    ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255)) - 128
                                                : int'($urandom_range(0, 120)) - 56,
                    ($urandom_range(0, 99) < 60),
                    ($urandom_range(0, 99) < 2),
                    "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
